// File: rtl/branch_local_predictor_if.sv
// Predict/update port bundle between the fetch stage, the branch resolution
// unit and the local-history branch predictor.
//
// Handshake: pred_valid_i and upd_valid_i are single-cycle request strobes
// with no backpressure. A strobe is accepted in exactly the cycles where
// ready_o=1 and is ignored otherwise. pred_valid_o is a single-cycle strobe
// one cycle after an accepted predict. The pred_* data outputs hold their
// values between strobes.
interface branch_local_predictor_if #(
  parameter int PC_W   = 32,
  parameter int HIST_W = 4,
  parameter int CTR_W  = 2
);
  logic              ready_o;
  logic              pred_valid_i;
  logic [PC_W-1:0]   pred_pc_i;
  logic              pred_valid_o;
  logic              pred_taken_o;
  logic [HIST_W-1:0] pred_hist_o;
  logic [CTR_W-1:0]  pred_ctr_o;
  logic              upd_valid_i;
  logic [PC_W-1:0]   upd_pc_i;
  logic [HIST_W-1:0] upd_hist_i;
  logic              upd_taken_i;

  // Fetch / resolution side
  modport master (
    input  ready_o, pred_valid_o, pred_taken_o, pred_hist_o, pred_ctr_o,
    output pred_valid_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i
  );

  // Predictor side
  modport slave (
    output ready_o, pred_valid_o, pred_taken_o, pred_hist_o, pred_ctr_o,
    input  pred_valid_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_hist_i, upd_taken_i
  );
endinterface

// File: rtl/branch_local_predictor.sv
// Two-level local-history branch predictor.
// The hashed PC selects a per-branch history register (BHT). That history,
// together with a few low PC bits, selects a saturating counter (PHT).
// Predictions are registered, so they appear one cycle after the request.
// After reset an INIT sweep clears the BHT and sets every PHT counter to
// weakly not-taken. Requests are accepted only once the sweep is done.
module branch_local_predictor #(
  parameter int PC_W      = 32,
  parameter int BHT_IDX_W = 4,
  parameter int HIST_W    = 4,
  parameter int PHT_PC_W  = 3,
  parameter int PC_SHIFT  = 2,
  parameter int CTR_W     = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  branch_local_predictor_if.slave  bp,
  output logic                     state_dbg_o  // 1 = RUN, 0 = INIT
);

  localparam int BHT_DEPTH = 1 << BHT_IDX_W;
  localparam int PHT_IDX_W = PHT_PC_W + HIST_W;
  localparam int PHT_DEPTH = 1 << PHT_IDX_W;

  localparam logic [PHT_IDX_W-1:0] PHT_LAST    = PHT_IDX_W'(PHT_DEPTH - 1);
  localparam logic [CTR_W-1:0]     CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0]     CTR_MAX     = {CTR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PHT_IDX_W-1:0]   cnt_q, cnt_d;
  logic                   pred_valid_q, pred_valid_d;
  logic [HIST_W-1:0]      pred_hist_q, pred_hist_d;
  logic [CTR_W-1:0]       pred_ctr_q, pred_ctr_d;
  logic [HIST_W-1:0]      bht_q [BHT_DEPTH];
  logic [HIST_W-1:0]      bht_d [BHT_DEPTH];
  logic [CTR_W-1:0]       pht_q [PHT_DEPTH];
  logic [CTR_W-1:0]       pht_d [PHT_DEPTH];

  // BHT index: XOR-fold of every BHT_IDX_W-bit slice of the PC
  function automatic logic [BHT_IDX_W-1:0] bidx(input logic [PC_W-1:0] pc);
    logic [BHT_IDX_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < PC_W / BHT_IDX_W; i++) begin
      acc = acc ^ pc[i*BHT_IDX_W +: BHT_IDX_W];
    end
    return acc;
  endfunction

  // PHT index: selected PC bits on top, history below
  function automatic logic [PHT_IDX_W-1:0] pidx(input logic [PC_W-1:0] pc,
                                                 input logic [HIST_W-1:0] h);
    return {pc[PC_SHIFT +: PHT_PC_W], h};
  endfunction

  logic [BHT_IDX_W-1:0] rd_bidx;
  logic [HIST_W-1:0]    rd_hist;
  logic [CTR_W-1:0]     rd_ctr;
  logic [BHT_IDX_W-1:0] upd_bidx;
  logic [PHT_IDX_W-1:0] upd_pidx;
  logic [CTR_W-1:0]     upd_ctr;
  logic [CTR_W-1:0]     upd_ctr_next;

  // Table reads use the registered contents, so a same-cycle update is not
  // visible to the prediction (read-before-write).
  always_comb begin
    rd_bidx      = bidx(bp.pred_pc_i);
    rd_hist      = bht_q[rd_bidx];
    rd_ctr       = pht_q[pidx(bp.pred_pc_i, rd_hist)];
    upd_bidx     = bidx(bp.upd_pc_i);
    upd_pidx     = pidx(bp.upd_pc_i, bp.upd_hist_i);
    upd_ctr      = pht_q[upd_pidx];
    upd_ctr_next = upd_ctr;
    if (bp.upd_taken_i && (upd_ctr != CTR_MAX)) begin
      upd_ctr_next = upd_ctr + 1'b1;
    end else if (!bp.upd_taken_i && (upd_ctr != '0)) begin
      upd_ctr_next = upd_ctr - 1'b1;
    end
  end

  // Next state: INIT sweep, then predict/update in RUN
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pred_valid_d = 1'b0;
    pred_hist_d  = pred_hist_q;
    pred_ctr_d   = pred_ctr_q;
    bht_d        = bht_q;
    pht_d        = pht_q;
    if (!resetn) begin
      state_d     = ST_INIT;
      cnt_d       = '0;
      pred_hist_d = '0;
      pred_ctr_d  = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          bht_d[cnt_q[BHT_IDX_W-1:0]] = '0;
          pht_d[cnt_q]                = CTR_WEAK_NT;
          cnt_d                       = cnt_q + 1'b1;
          if (cnt_q == PHT_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bp.pred_valid_i) begin
            pred_valid_d = 1'b1;
            pred_hist_d  = rd_hist;
            pred_ctr_d   = rd_ctr;
          end
          if (bp.upd_valid_i) begin
            // The counter is indexed with the history carried by the branch,
            // not with whatever the BHT holds now.
            pht_d[upd_pidx] = upd_ctr_next;
            bht_d[upd_bidx] = {bht_q[upd_bidx][HIST_W-2:0], bp.upd_taken_i};
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // State, prediction and table registers
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    cnt_q        <= cnt_d;
    pred_valid_q <= pred_valid_d;
    pred_hist_q  <= pred_hist_d;
    pred_ctr_q   <= pred_ctr_d;
    bht_q        <= bht_d;
    pht_q        <= pht_d;
  end

  // Outputs are forced low for as long as resetn is held low
  assign bp.ready_o      = resetn & (state_q == ST_RUN);
  assign bp.pred_valid_o = resetn & pred_valid_q;
  assign bp.pred_hist_o  = resetn ? pred_hist_q : '0;
  assign bp.pred_ctr_o   = resetn ? pred_ctr_q : '0;
  assign bp.pred_taken_o = resetn & pred_ctr_q[CTR_W-1];
  assign state_dbg_o     = (state_q == ST_RUN);

endmodule

// File: tb/tb_branch_local_predictor.sv
// Directed bench for the local-history branch predictor (default parameters:
// 16-entry BHT, 4-bit history, 128-entry PHT of 2-bit counters).
module tb_branch_local_predictor;

  logic clk;
  logic resetn;
  logic state_dbg;
  int   checks;
  int   failures;
  int   init_cycles;
  int   init_valids;

  branch_local_predictor_if #(.PC_W(32), .HIST_W(4), .CTR_W(2)) bp_if ();

  branch_local_predictor dut (
    .clk         (clk),
    .resetn      (resetn),
    .bp          (bp_if),
    .state_dbg_o (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point: counts every check and every failure
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled #1 after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic [31:0] pc);
    bp_if.pred_valid_i = 1'b1;
    bp_if.pred_pc_i    = pc;
    tick();
    bp_if.pred_valid_i = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [3:0] hist, input logic taken);
    bp_if.upd_valid_i = 1'b1;
    bp_if.upd_pc_i    = pc;
    bp_if.upd_hist_i  = hist;
    bp_if.upd_taken_i = taken;
    tick();
    bp_if.upd_valid_i = 1'b0;
  endtask

  task automatic chk_pred(input string tag, input logic taken, input logic [1:0] ctr,
                          input logic [3:0] hist);
    chk({tag, "_valid"}, 32'(bp_if.pred_valid_o), 32'd1);
    chk({tag, "_taken"}, 32'(bp_if.pred_taken_o), 32'(taken));
    chk({tag, "_ctr"},   32'(bp_if.pred_ctr_o),   32'(ctr));
    chk({tag, "_hist"},  32'(bp_if.pred_hist_o),  32'(hist));
  endtask

  // Counts INIT cycles (ready_o low) after reset release, bounded
  task automatic run_init(input logic [31:0] pc);
    init_cycles = 0;
    init_valids = 0;
    bp_if.pred_valid_i = 1'b1;
    bp_if.pred_pc_i    = pc;
    bp_if.upd_valid_i  = 1'b1;
    bp_if.upd_pc_i     = pc;
    bp_if.upd_hist_i   = 4'h0;
    bp_if.upd_taken_i  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bp_if.ready_o) break;
      init_cycles++;
      if (bp_if.pred_valid_o) init_valids++;
      tick();
    end
    bp_if.pred_valid_i = 1'b0;
    bp_if.upd_valid_i  = 1'b0;
  endtask

  // Directed sequence
  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    bp_if.pred_valid_i = 1'b0;
    bp_if.pred_pc_i    = '0;
    bp_if.upd_valid_i  = 1'b0;
    bp_if.upd_pc_i     = '0;
    bp_if.upd_hist_i   = '0;
    bp_if.upd_taken_i  = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_ready", 32'(bp_if.ready_o), 32'd0);
    chk("rst_valid", 32'(bp_if.pred_valid_o), 32'd0);
    chk("rst_hist",  32'(bp_if.pred_hist_o), 32'd0);
    chk("rst_ctr",   32'(bp_if.pred_ctr_o), 32'd0);

    // INIT lasts exactly 128 cycles; requests during INIT are ignored
    resetn = 1'b1;
    run_init(32'h40);
    chk("init_cycles", 32'(init_cycles), 32'd128);
    chk("init_no_valid", 32'(init_valids), 32'd0);
    chk("init_ready", 32'(bp_if.ready_o), 32'd1);
    chk("init_state_dbg", 32'(state_dbg), 32'd1);
    chk("init_last_valid", 32'(bp_if.pred_valid_o), 32'd0);

    // First prediction: weakly not-taken, empty history
    predict(32'h40);
    chk_pred("p40_first", 1'b0, 2'd1, 4'b0000);
    tick();
    chk("idle_valid", 32'(bp_if.pred_valid_o), 32'd0);
    chk("idle_hold_ctr", 32'(bp_if.pred_ctr_o), 32'd1);

    // Three taken updates with hist 0000: PHT[0] 1->2->3->3, BHT[4] -> 0111
    update(32'h40, 4'b0000, 1'b1);
    update(32'h40, 4'b0000, 1'b1);
    update(32'h40, 4'b0000, 1'b1);
    predict(32'h40);
    chk_pred("p40_after_upd", 1'b0, 2'd1, 4'b0111);
    // 0x80: bidx 8 (history 0000), PC bits 000 -> reads PHT[0]
    predict(32'h80);
    chk_pred("p80_sat", 1'b1, 2'd3, 4'b0000);

    // Same-cycle predict and update of 0x40: prediction sees old tables
    bp_if.upd_valid_i  = 1'b1;
    bp_if.upd_pc_i     = 32'h40;
    bp_if.upd_hist_i   = 4'b0111;
    bp_if.upd_taken_i  = 1'b1;
    predict(32'h40);
    bp_if.upd_valid_i  = 1'b0;
    chk_pred("rbw_pred", 1'b0, 2'd1, 4'b0111);
    predict(32'h40);
    chk_pred("rbw_after", 1'b0, 2'd1, 4'b1111);

    // Aliasing: 0x10 and 0x01 share BHT[1]
    update(32'h10, 4'b0000, 1'b1);
    predict(32'h01);
    chk_pred("alias_01", 1'b0, 2'd1, 4'b0001);

    // Not-taken decrement: PHT[0] 3->2, BHT[8] stays 0000
    update(32'h80, 4'b0000, 1'b0);
    predict(32'h80);
    chk_pred("dec_80", 1'b1, 2'd2, 4'b0000);

    // Saturate at 0: PHT[1] 1->0->0, BHT[1] 0001->0010->0100
    update(32'h01, 4'b0001, 1'b0);
    update(32'h01, 4'b0001, 1'b0);
    // 0x02: bidx 2; BHT[2] -> 0001, PHT[5] -> 2; then read PHT[1]
    update(32'h02, 4'b0101, 1'b1);
    predict(32'h02);
    chk_pred("sat0_02", 1'b0, 2'd0, 4'b0001);
    predict(32'h01);
    chk_pred("hist_01", 1'b0, 2'd1, 4'b0100);

    // Reset mid-RUN with a predict in flight
    bp_if.pred_valid_i = 1'b1;
    bp_if.pred_pc_i    = 32'h80;
    tick();
    resetn = 1'b0;
    bp_if.pred_valid_i = 1'b1;
    bp_if.pred_pc_i    = 32'h40;
    tick();
    bp_if.pred_valid_i = 1'b0;
    chk("mid_rst_valid", 32'(bp_if.pred_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(bp_if.ready_o), 32'd0);
    chk("mid_rst_ctr",   32'(bp_if.pred_ctr_o), 32'd0);
    resetn = 1'b1;
    run_init(32'h80);
    chk("reinit_cycles", 32'(init_cycles), 32'd128);
    chk("reinit_no_valid", 32'(init_valids), 32'd0);
    chk("reinit_ready", 32'(bp_if.ready_o), 32'd1);

    // Tables are back to their init values
    predict(32'h40);
    chk_pred("reinit_40", 1'b0, 2'd1, 4'b0000);
    predict(32'h80);
    chk_pred("reinit_80", 1'b0, 2'd1, 4'b0000);
    predict(32'h01);
    chk_pred("reinit_01", 1'b0, 2'd1, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
